// File: rtl/el2_pkg.sv
// Shared types for the LSU address-check arbiter: request/response packets,
// size encodings and the response-register state.
package el2_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } el2_arb_state_e;

  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
    logic [3:0]  rs1_region;
    logic [1:0]  size;
    logic        store;
    logic        dma;
  } el2_addrchk_req_t;

  typedef struct packed {
    logic       in_dccm;
    logic       in_pic;
    logic       external;
    logic       access_fault;
    logic       misaligned_fault;
    logic [3:0] mscause;
    logic       dma_err;
  } el2_addrchk_rsp_t;

endpackage

// File: rtl/el2_lsu_addrchk_arb_if.sv
// Bus bundle between the core/DMA front-ends, the address checker and the
// response consumer. slave = arbiter view, master = environment view.
interface el2_lsu_addrchk_arb_if;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [31:0] core_start_addr;
  logic [31:0] core_end_addr;
  logic [3:0]  core_rs1_region;
  logic [1:0]  core_size;
  logic        core_store;

  logic        dma_req_valid;
  logic        dma_req_ready;
  logic [31:0] dma_start_addr;
  logic [31:0] dma_end_addr;
  logic        dma_store;

  logic        chk_valid;
  logic        chk_dma;
  logic        chk_load;
  logic        chk_store;
  logic        chk_by;
  logic        chk_half;
  logic        chk_word;
  logic [31:0] chk_start_addr;
  logic [31:0] chk_end_addr;
  logic [3:0]  chk_rs1_region;
  logic        chk_in_dccm;
  logic        chk_in_pic;
  logic        chk_external;
  logic        chk_access_fault;
  logic        chk_misaligned_fault;
  logic [3:0]  chk_mscause;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_dma;
  logic        rsp_in_dccm;
  logic        rsp_in_pic;
  logic        rsp_external;
  logic        rsp_access_fault;
  logic        rsp_misaligned_fault;
  logic [3:0]  rsp_mscause;
  logic        rsp_dma_err;

  modport slave (
    input  core_req_valid, core_start_addr, core_end_addr, core_rs1_region, core_size, core_store,
    output core_req_ready,
    input  dma_req_valid, dma_start_addr, dma_end_addr, dma_store,
    output dma_req_ready,
    output chk_valid, chk_dma, chk_load, chk_store, chk_by, chk_half, chk_word,
    output chk_start_addr, chk_end_addr, chk_rs1_region,
    input  chk_in_dccm, chk_in_pic, chk_external, chk_access_fault, chk_misaligned_fault, chk_mscause,
    input  rsp_ready,
    output rsp_valid, rsp_dma, rsp_in_dccm, rsp_in_pic, rsp_external,
    output rsp_access_fault, rsp_misaligned_fault, rsp_mscause, rsp_dma_err
  );

  modport master (
    output core_req_valid, core_start_addr, core_end_addr, core_rs1_region, core_size, core_store,
    input  core_req_ready,
    output dma_req_valid, dma_start_addr, dma_end_addr, dma_store,
    input  dma_req_ready,
    input  chk_valid, chk_dma, chk_load, chk_store, chk_by, chk_half, chk_word,
    input  chk_start_addr, chk_end_addr, chk_rs1_region,
    output chk_in_dccm, chk_in_pic, chk_external, chk_access_fault, chk_misaligned_fault, chk_mscause,
    output rsp_ready,
    input  rsp_valid, rsp_dma, rsp_in_dccm, rsp_in_pic, rsp_external,
    input  rsp_access_fault, rsp_misaligned_fault, rsp_mscause, rsp_dma_err
  );
endinterface

// File: rtl/el2_lsu_addrchk_starve_ctr.sv
// DMA starvation counter: counts cycles a pending DMA request loses to the
// core and forces the DMA to win once the count reaches MAX.
module el2_lsu_addrchk_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_valid,
  input  logic gnt_dma,
  input  logic gnt_core,
  output logic force_dma
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] cnt_q;

  // Clear when DMA is served or withdraws; count losses only on real core grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_q <= '0;
    else if (!dma_valid || gnt_dma)   cnt_q <= '0;
    else if (gnt_core && cnt_q != MAX_C) cnt_q <= cnt_q + 8'd1;
  end

  assign force_dma = (cnt_q == MAX_C);

endmodule

// File: rtl/el2_lsu_addrchk_arb.sv
// Core/DMA arbiter in front of the shared LSU address checker, with a
// one-entry registered response. Optional statistics counters are built
// when EL2_ADDRCHK_ARB_STATS_EN is defined.
module el2_lsu_addrchk_arb
  import el2_pkg::*;
#(
  parameter int DMA_MAX_STALL = 4,
  parameter int DCCM_ENABLE   = 1
) (
  input  logic clk,
  input  logic rst,
  el2_lsu_addrchk_arb_if.slave bus
`ifdef EL2_ADDRCHK_ARB_STATS_EN
  , output logic [15:0] stat_core_faults
  , output logic [15:0] stat_dma_errs
`endif
);

  el2_arb_state_e   state_q, state_d;
  el2_addrchk_req_t core_req, dma_req, sel_req;
  el2_addrchk_rsp_t rsp_d, rsp_q;
  logic             rsp_dma_q;
  logic             can_accept, force_dma, dma_win;
  logic             gnt_core, gnt_dma, gnt;

  // A grant is only possible when the response slot is free or draining
  assign can_accept = (state_q == ST_EMPTY) | bus.rsp_ready;
  assign dma_win    = bus.dma_req_valid & (~bus.core_req_valid | force_dma);
  assign gnt_dma    = can_accept & dma_win;
  assign gnt_core   = can_accept & bus.core_req_valid & ~dma_win;
  assign gnt        = gnt_core | gnt_dma;

  assign bus.core_req_ready = gnt_core;
  assign bus.dma_req_ready  = gnt_dma;

  el2_lsu_addrchk_starve_ctr #(.MAX(DMA_MAX_STALL)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .dma_valid (bus.dma_req_valid),
    .gnt_dma   (gnt_dma),
    .gnt_core  (gnt_core),
    .force_dma (force_dma)
  );

  assign core_req = '{start_addr: bus.core_start_addr, end_addr: bus.core_end_addr,
                      rs1_region: bus.core_rs1_region, size: bus.core_size,
                      store: bus.core_store, dma: 1'b0};
  // DMA is always a word access; its region comes from the address itself
  assign dma_req  = '{start_addr: bus.dma_start_addr, end_addr: bus.dma_end_addr,
                      rs1_region: bus.dma_start_addr[31:28], size: SZ_WORD,
                      store: bus.dma_store, dma: 1'b1};

  // Select the granted packet; idle drives an all-zero packet
  always_comb begin
    sel_req = '0;
    if (gnt_dma)       sel_req = dma_req;
    else if (gnt_core) sel_req = core_req;
  end

  assign bus.chk_valid      = gnt;
  assign bus.chk_dma        = sel_req.dma;
  assign bus.chk_load       = gnt & ~sel_req.store;
  assign bus.chk_store      = sel_req.store;
  assign bus.chk_by         = gnt & (sel_req.size == SZ_BYTE);
  assign bus.chk_half       = gnt & (sel_req.size == SZ_HALF);
  assign bus.chk_word       = gnt & (sel_req.size == SZ_WORD);
  assign bus.chk_start_addr = sel_req.start_addr;
  assign bus.chk_end_addr   = sel_req.end_addr;
  assign bus.chk_rs1_region = sel_req.rs1_region;

  // Checker result as it will be captured; DMA outside DCCM/PIC is an error
  always_comb begin
    rsp_d                  = '0;
    rsp_d.in_dccm          = bus.chk_in_dccm;
    rsp_d.in_pic           = bus.chk_in_pic;
    rsp_d.external         = bus.chk_external;
    rsp_d.access_fault     = bus.chk_access_fault;
    rsp_d.misaligned_fault = bus.chk_misaligned_fault;
    rsp_d.mscause          = bus.chk_mscause;
    rsp_d.dma_err          = gnt_dma & ((DCCM_ENABLE == 0) | ~(bus.chk_in_dccm | bus.chk_in_pic));
  end

  // Response-slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Fill on any grant; drain only when consumed with nothing new behind it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (gnt) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !gnt) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Capture the checker result on grant; back-to-back grants overwrite in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q     <= '0;
      rsp_dma_q <= 1'b0;
    end else if (gnt) begin
      rsp_q     <= rsp_d;
      rsp_dma_q <= gnt_dma;
    end
  end

  assign bus.rsp_valid            = (state_q == ST_FULL);
  assign bus.rsp_dma              = rsp_dma_q;
  assign bus.rsp_in_dccm          = rsp_q.in_dccm;
  assign bus.rsp_in_pic           = rsp_q.in_pic;
  assign bus.rsp_external         = rsp_q.external;
  assign bus.rsp_access_fault     = rsp_q.access_fault;
  assign bus.rsp_misaligned_fault = rsp_q.misaligned_fault;
  assign bus.rsp_mscause          = rsp_q.mscause;
  assign bus.rsp_dma_err          = rsp_q.dma_err;

`ifdef EL2_ADDRCHK_ARB_STATS_EN
  logic [15:0] core_faults_q, dma_errs_q;

  // Saturating tallies of faulting core responses and erroring DMA responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_faults_q <= '0;
      dma_errs_q    <= '0;
    end else begin
      if (gnt_core && (bus.chk_access_fault || bus.chk_misaligned_fault) && core_faults_q != 16'hFFFF)
        core_faults_q <= core_faults_q + 16'd1;
      if (gnt_dma && rsp_d.dma_err && dma_errs_q != 16'hFFFF)
        dma_errs_q <= dma_errs_q + 16'd1;
    end
  end

  assign stat_core_faults = core_faults_q;
  assign stat_dma_errs    = dma_errs_q;
`endif

endmodule

// File: tb/tb_el2_lsu_addrchk_arb.sv
// Self-checking bench for el2_lsu_addrchk_arb: fixed vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_el2_lsu_addrchk_arb;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  el2_lsu_addrchk_arb_if bus ();

`ifdef EL2_ADDRCHK_ARB_STATS_EN
  logic [15:0] stat_core_faults, stat_dma_errs;
`endif

  el2_lsu_addrchk_arb #(.DMA_MAX_STALL(MAXS), .DCCM_ENABLE(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef EL2_ADDRCHK_ARB_STATS_EN
    , .stat_core_faults (stat_core_faults)
    , .stat_dma_errs    (stat_dma_errs)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: slot occupancy, held response, consecutive DMA losses
  bit          m_full;
  logic [10:0] m_rsp;
  int          m_loss;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [74:0] act_chk();
    return {bus.chk_valid, bus.chk_dma, bus.chk_load, bus.chk_store, bus.chk_by, bus.chk_half,
            bus.chk_word, bus.chk_start_addr, bus.chk_end_addr, bus.chk_rs1_region};
  endfunction

  function automatic logic [10:0] act_rsp();
    return {bus.rsp_dma, bus.rsp_in_dccm, bus.rsp_in_pic, bus.rsp_external, bus.rsp_access_fault,
            bus.rsp_misaligned_fault, bus.rsp_mscause, bus.rsp_dma_err};
  endfunction

  function automatic logic [74:0] exp_chk(input logic gc, input logic gd);
    logic [74:0] r;
    r = '0;
    if (gd)
      r = {1'b1, 1'b1, ~bus.dma_store, bus.dma_store, 3'b001,
           bus.dma_start_addr, bus.dma_end_addr, bus.dma_start_addr[31:28]};
    else if (gc)
      r = {1'b1, 1'b0, ~bus.core_store, bus.core_store,
           bus.core_size == 2'd0, bus.core_size == 2'd1, bus.core_size == 2'd2,
           bus.core_start_addr, bus.core_end_addr, bus.core_rs1_region};
    return r;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance model, check response
  task automatic cyc();
    logic ca, dw, gc, gd, dv, rr;
    logic [10:0] nr;
    @(negedge clk);
    ca = !m_full || bus.rsp_ready;
    dw = bus.dma_req_valid && (!bus.core_req_valid || m_loss == MAXS);
    gd = ca && dw;
    gc = ca && bus.core_req_valid && !dw;
    check("core_req_ready", 128'(bus.core_req_ready), 128'(gc));
    check("dma_req_ready", 128'(bus.dma_req_ready), 128'(gd));
    check("chk_packet", 128'(act_chk()), 128'(exp_chk(gc, gd)));
    nr = {gd, bus.chk_in_dccm, bus.chk_in_pic, bus.chk_external, bus.chk_access_fault,
          bus.chk_misaligned_fault, bus.chk_mscause, gd && !(bus.chk_in_dccm || bus.chk_in_pic)};
    dv = bus.dma_req_valid;
    rr = bus.rsp_ready;
    @(posedge clk);
    if (gc || gd) begin
      m_full = 1'b1;
      m_rsp  = nr;
    end else if (rr) m_full = 1'b0;
    if (!dv || gd)  m_loss = 0;
    else if (gc)    m_loss = (m_loss + 1 > MAXS) ? MAXS : m_loss + 1;
    #1;
    check("rsp_valid", 128'(bus.rsp_valid), 128'(m_full));
    if (m_full) check("rsp_data", 128'(act_rsp()), 128'(m_rsp));
  endtask

  task automatic idle_inputs();
    bus.core_req_valid = 1'b0; bus.core_start_addr = '0; bus.core_end_addr = '0;
    bus.core_rs1_region = '0; bus.core_size = '0; bus.core_store = 1'b0;
    bus.dma_req_valid = 1'b0; bus.dma_start_addr = '0; bus.dma_end_addr = '0; bus.dma_store = 1'b0;
    bus.chk_in_dccm = 1'b0; bus.chk_in_pic = 1'b0; bus.chk_external = 1'b0;
    bus.chk_access_fault = 1'b0; bus.chk_misaligned_fault = 1'b0; bus.chk_mscause = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    cyc();
  endtask

  typedef struct {
    logic cv; logic [1:0] csz; logic cst; logic [31:0] cs, ce; logic [3:0] creg;
    logic dv; logic dst; logic [31:0] ds, de;
    logic [8:0] res;   // {in_dccm, in_pic, external, access_fault, misaligned_fault, mscause}
    logic ecr, edr, erv;
    logic [10:0] ersp; // {dma, in_dccm, in_pic, external, af, mf, mscause, dma_err}
  } vec_t;

  vec_t vt[7];
  logic [10:0] held;

  initial begin
    idle_inputs();
    m_full = 1'b0; m_rsp = '0; m_loss = 0;

    // Reset state
    #3;
    check("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("reset_rsp_data", 128'(act_rsp()), 128'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single-transaction vectors, each from an empty slot
    vt[0] = '{1'b1, 2'd2, 1'b0, 32'hF004_0000, 32'hF004_0003, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0,
              9'b100000000, 1'b1, 1'b0, 1'b1, 11'b01000000000};
    vt[1] = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h2000_0000, 32'h2000_0003,
              9'b000000000, 1'b0, 1'b1, 1'b1, 11'b10000000001};
    vt[2] = '{1'b1, 2'd1, 1'b1, 32'hF004_0001, 32'hF004_0002, 4'hF, 1'b1, 1'b1, 32'hF004_0100, 32'hF004_0103,
              9'b000010010, 1'b1, 1'b0, 1'b1, 11'b00000100100};
    vt[3] = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hF00C_0000, 32'hF00C_0003,
              9'b010000000, 1'b0, 1'b1, 1'b1, 11'b10100000000};
    vt[4] = '{1'b1, 2'd3, 1'b0, 32'h8000_0010, 32'h8000_0013, 4'h8, 1'b0, 1'b0, 32'h0, 32'h0,
              9'b001100011, 1'b1, 1'b0, 1'b1, 11'b00011000110};
    vt[5] = '{1'b0, 2'd0, 1'b0, 32'h1234_5678, 32'h1234_5678, 4'h1, 1'b0, 1'b1, 32'h0, 32'h0,
              9'b100000000, 1'b0, 1'b0, 1'b0, 11'b00000000000};
    vt[6] = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hF004_0040, 32'hF004_0043,
              9'b100000000, 1'b0, 1'b1, 1'b1, 11'b11000000000};
    for (int i = 0; i < 7; i++) begin
      bus.core_req_valid = vt[i].cv; bus.core_size = vt[i].csz; bus.core_store = vt[i].cst;
      bus.core_start_addr = vt[i].cs; bus.core_end_addr = vt[i].ce; bus.core_rs1_region = vt[i].creg;
      bus.dma_req_valid = vt[i].dv; bus.dma_store = vt[i].dst;
      bus.dma_start_addr = vt[i].ds; bus.dma_end_addr = vt[i].de;
      {bus.chk_in_dccm, bus.chk_in_pic, bus.chk_external, bus.chk_access_fault,
       bus.chk_misaligned_fault, bus.chk_mscause} = vt[i].res;
      #1;
      check($sformatf("vec%0d_core_ready", i), 128'(bus.core_req_ready), 128'(vt[i].ecr));
      check($sformatf("vec%0d_dma_ready", i), 128'(bus.dma_req_ready), 128'(vt[i].edr));
      cyc();
      check($sformatf("vec%0d_rsp_valid", i), 128'(bus.rsp_valid), 128'(vt[i].erv));
      if (vt[i].erv) check($sformatf("vec%0d_rsp", i), 128'(act_rsp()), 128'(vt[i].ersp));
      drain();
    end

    // Starvation: core wins MAXS cycles, then DMA is forced through once
    idle_inputs();
    bus.core_req_valid = 1'b1; bus.core_size = 2'd2; bus.core_start_addr = 32'hF004_0000;
    bus.dma_req_valid = 1'b1; bus.dma_start_addr = 32'hF004_0200; bus.chk_in_dccm = 1'b1;
    for (int i = 0; i < MAXS + 2; i++) begin
      #1;
      check($sformatf("starve%0d_core", i), 128'(bus.core_req_ready), 128'(i != MAXS));
      check($sformatf("starve%0d_dma", i), 128'(bus.dma_req_ready), 128'(i == MAXS));
      cyc();
    end
    drain();

    // Hold with rsp_ready low: readies drop, response stable, loss count frozen
    idle_inputs();
    bus.core_req_valid = 1'b1; bus.core_start_addr = 32'hF004_0010; bus.core_size = 2'd2;
    bus.dma_req_valid = 1'b1; bus.dma_start_addr = 32'hF004_0300; bus.chk_in_dccm = 1'b1;
    cyc();
    held = m_rsp;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.chk_in_dccm = ~bus.chk_in_dccm; bus.chk_mscause = 4'(i + 5);
      #1;
      check($sformatf("hold%0d_core", i), 128'(bus.core_req_ready), 128'(0));
      check($sformatf("hold%0d_dma", i), 128'(bus.dma_req_ready), 128'(0));
      cyc();
      check($sformatf("hold%0d_rsp", i), 128'(act_rsp()), 128'(held));
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < MAXS; i++) begin
      #1;
      check($sformatf("release%0d_dma", i), 128'(bus.dma_req_ready), 128'(i == MAXS - 1));
      cyc();
    end
    drain();

    // Back-to-back: core misaligned fault, then DMA with no bubble
    idle_inputs();
    bus.core_req_valid = 1'b1; bus.core_size = 2'd2; bus.core_start_addr = 32'hF004_0002;
    bus.chk_misaligned_fault = 1'b1; bus.chk_mscause = 4'h2;
    cyc();
    check("b2b_first_valid", 128'(bus.rsp_valid), 128'(1));
    check("b2b_first_mscause", 128'(bus.rsp_mscause), 128'(4'h2));
    check("b2b_first_dma", 128'(bus.rsp_dma), 128'(0));
    idle_inputs();
    bus.dma_req_valid = 1'b1; bus.dma_start_addr = 32'hF004_0400; bus.chk_in_dccm = 1'b1;
    #1 check("b2b_dma_ready", 128'(bus.dma_req_ready), 128'(1));
    cyc();
    check("b2b_second_valid", 128'(bus.rsp_valid), 128'(1));
    check("b2b_second_dma", 128'(bus.rsp_dma), 128'(1));
    check("b2b_second_err", 128'(bus.rsp_dma_err), 128'(0));

    // Asynchronous reset while full drops the response without a clock edge
    idle_inputs();
    bus.rsp_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(bus.rsp_valid), 128'(0));
    check("async_rst_data", 128'(act_rsp()), 128'(0));
    m_full = 1'b0; m_rsp = '0; m_loss = 0;
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.core_req_valid       = ($urandom_range(0, 9) < 6);
      bus.core_start_addr      = $urandom;
      bus.core_end_addr        = $urandom;
      bus.core_rs1_region      = 4'($urandom);
      bus.core_size            = 2'($urandom);
      bus.core_store           = 1'($urandom);
      bus.dma_req_valid        = ($urandom_range(0, 9) < 5);
      bus.dma_start_addr       = $urandom;
      bus.dma_end_addr         = $urandom;
      bus.dma_store            = 1'($urandom);
      bus.chk_in_dccm          = 1'($urandom);
      bus.chk_in_pic           = 1'($urandom);
      bus.chk_external         = 1'($urandom);
      bus.chk_access_fault     = 1'($urandom);
      bus.chk_misaligned_fault = 1'($urandom);
      bus.chk_mscause          = 4'($urandom);
      bus.rsp_ready            = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/el2_lsu_addrchk_arb.md
Name: el2_lsu_addrchk_arb

Overview:
- Shares a single LSU address-check datapath between two requesters: the core load/store D-stage and the DMA slave port.
- Arbitrates between them and drives the selected request into the checker.
- Captures the checker's combinational result into a one-entry response register with a valid/ready handshake.
- Guarantees DMA forward progress with a starvation counter. Sits between the decode/DMA front-ends and the address checker in the LSU.

Parameters:
- DMA_MAX_STALL, 4, cycles a pending DMA request may lose to the core before it is forced to win (legal 1..255).
- DCCM_ENABLE, 1, when 0 every DMA response reports dma_err.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- core_req_valid  in  1  core request present
- core_req_ready  out  1  core request accepted this cycle
- core_start_addr  in  32  core start address
- core_end_addr  in  32  core end address
- core_rs1_region  in  4  base register [31:28]
- core_size  in  2  0=byte, 1=half, 2=word
- core_store  in  1  1=store, 0=load
- dma_req_valid  in  1  DMA request present
- dma_req_ready  out  1  DMA request accepted
- dma_start_addr  in  32  DMA start address
- dma_end_addr  in  32  DMA end address
- dma_store  in  1  1=store, 0=load
- chk_valid  out  1  packet valid to checker
- chk_dma  out  1  packet is DMA
- chk_load  out  1  packet is a load
- chk_store  out  1  packet is a store
- chk_by  out  1  byte size
- chk_half  out  1  half size
- chk_word  out  1  word size
- chk_start_addr  out  32  start address to checker
- chk_end_addr  out  32  end address to checker
- chk_rs1_region  out  4  region to checker
- chk_in_dccm  in  1  checker result
- chk_in_pic  in  1  checker result
- chk_external  in  1  checker result
- chk_access_fault  in  1  checker result
- chk_misaligned_fault  in  1  checker result
- chk_mscause  in  4  checker result
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_dma  out  1  response belongs to DMA
- rsp_in_dccm  out  1  registered result
- rsp_in_pic  out  1  registered result
- rsp_external  out  1  registered result
- rsp_access_fault  out  1  registered result
- rsp_misaligned_fault  out  1  registered result
- rsp_mscause  out  4  registered result
- rsp_dma_err  out  1  DMA target not in DCCM or PIC

Behaviour:
- Reset values: all rsp_* outputs 0, starve_cnt 0, state EMPTY.
- States:
  - EMPTY: response register empty.
  - FULL: response register holds a result.
  - EMPTY -> FULL on any grant.
  - FULL -> EMPTY when rsp_ready and no grant.
  - FULL -> FULL when rsp_ready and grant (back-to-back).
  - FULL -> FULL when ~rsp_ready; no grant is possible in this case.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant rules:
  - Core wins by default.
  - DMA wins if dma_req_valid & (~core_req_valid | starve_cnt==DMA_MAX_STALL).
  - core_req_ready = can_accept & core granted.
  - dma_req_ready = can_accept & DMA granted.
  - At most one ready per cycle.
- Checker drive:
  - chk_* is a combinational mux of the granted request; chk_valid = grant & can_accept.
  - For the core path: chk_dma=0, and by/half/word are decoded from core_size (size 3 drives all three low).
  - For the DMA path: chk_dma=1, chk_word=1, chk_rs1_region=dma_start_addr[31:28].
  - When nothing is granted, chk_* = 0.
- Latency: request accepted in cycle N; checker sampled in cycle N; rsp_valid in cycle N+1.
- rsp_dma_err = DMA & ~(chk_in_dccm | chk_in_pic), registered with the response. It is always 0 for core responses.
- starve_cnt:
  - Increments (saturating at DMA_MAX_STALL) each cycle dma_req_valid & ~dma_req_ready & core granted.
  - Clears on a DMA grant, or when dma_req_valid is low.
  - It does not increment while can_accept is low.
- Simultaneous events: rsp_ready with a new grant in the same cycle overwrites the register with no bubble.
- Asynchronous reset mid-transfer drops the held response; requesters must re-present.

Optional Feature:
- Macro EL2_ADDRCHK_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_core_faults[15:0] and stat_dma_errs[15:0].
  - Both are saturating counters, incremented on response capture when (access_fault|misaligned_fault) for core, or dma_err for DMA.
  - Both reset to 0.
- When undefined: these ports and counters are absent.

Decomposition:
- Shared package (el2_pkg):
  - el2_addrchk_req_t: addresses, region, size, store, dma.
  - el2_addrchk_rsp_t: in_dccm, in_pic, external, faults, mscause, dma_err.
  - Size encoding constants: SZ_BYTE, SZ_HALF, SZ_WORD.
- Sub-module el2_lsu_addrchk_starve_ctr, holding the saturating starvation counter and its forced-grant compare.

Test Plan:
- Core-only word load at 0xF004_0000, checker returns in_dccm=1 -> core_req_ready in cycle 0; rsp_valid=1, rsp_in_dccm=1, rsp_dma=0 in cycle 1.
- Core and DMA both valid continuously, DMA_MAX_STALL=4 -> core granted 4 cycles, DMA granted in the 5th, starve_cnt returns to 0.
- Response held with rsp_ready=0 for 3 cycles -> both readies stay 0, rsp_* stable, starve_cnt frozen.
- DMA to 0x2000_0000 with checker in_dccm=0, in_pic=0 -> rsp_dma_err=1, rsp_access_fault follows the checker (0).
- Core misaligned fault with mscause 4'h2, rsp_ready=1 with a back-to-back DMA -> consecutive responses with no bubble; the first has rsp_mscause=2.
- Assert rst while state FULL -> rsp_valid drops to 0 immediately, without waiting for a clock edge.
